cache_profile_streamer: RTL and testbench
=========================================

Name: cache_profile_streamer

Overview:
- Downstream consumer of the cache profiler's eight 32-bit counters.
- On a snapshot request, captures all counters in a single cycle so the frame is coherent.
- Emits them as a framed word stream (header, counters, optional checksum) over a valid/ready interface to the host readout path (UART/debug FIFO).
- Owns sequencing, capture, back-pressure and dropped-request accounting.

Parameters:
NUM_COUNTERS, 8, number of 32-bit counter slots captured per frame (1..255)
HDR_MAGIC, 16'hCA5E, upper 16 bits of every header word

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
snapshot_req  in  1  capture request; sampled every cycle
counters_in  in  32*NUM_COUNTERS  packed counters, slot k = bits [32k+31:32k]; slot order: icache_request, icache_hit, icache_miss, dcache_request, dcache_hit, dcache_miss, icache_fill_latency, dcache_fill_latency
out_data  out  32  stream word
out_valid  out  1  word valid
out_ready  in  1  sink accepts word
out_last  out  1  final word of frame, qualified by out_valid
busy  out  1  high whenever state != IDLE
dropped_req_count  out  8  requests ignored while busy, saturating

Behaviour:
- Reset values: state=IDLE; out_valid=0, out_last=0, out_data=0, busy=0; seq_id=0; dropped_req_count=0; capture registers=0.
- Reset asserted mid-frame aborts the frame. out_valid=0 from the next edge, with no partial completion.
- FSM states: IDLE, HEADER, DATA, CHECK (CHECK only with the optional feature).
- IDLE:
  - snapshot_req=1 at edge N: latch all counters_in into capture registers at that same edge.
  - State -> HEADER; out_valid=1 from cycle N+1 (one-cycle request-to-header latency).
- Header word = {HDR_MAGIC, seq_id[7:0], NUM_COUNTERS[7:0]}.
- Handshake:
  - Word transfers on a cycle with out_valid & out_ready.
  - out_data, out_valid and out_last are registered and must stay stable while out_valid & ~out_ready.
  - No combinational path from out_ready to out_valid.
- HEADER --xfer--> DATA, idx=0.
- DATA:
  - out_data = capture[idx]; xfer increments idx.
  - On xfer at idx=NUM_COUNTERS-1: -> IDLE, or -> CHECK if feature enabled.
- out_last=1 only on the final word of the frame: last DATA word, or the CHECK word when enabled.
- Frame completion:
  - seq_id increments by 1 at the final word's xfer, wrapping 255->0.
  - Next capture is accepted no earlier than the cycle after the final xfer, so there is exactly one idle cycle between frames when out_ready stays high.
- snapshot_req while busy: ignored (no re-capture, no queueing); dropped_req_count += 1, saturating at 255.
- snapshot_req coinciding with the final xfer counts as dropped (state is not yet IDLE).
- Throughput with out_ready held high: frame length = 1 + NUM_COUNTERS (+1) cycles.
- Capture registers are unchanged for the whole frame, whatever counters_in does.

Optional Feature:
- Macro PROFILER_STREAM_CHECKSUM_EN.
- Defined:
  - After the last DATA word, emit CHECK word = XOR of header word and all NUM_COUNTERS captured words; out_last moves to CHECK.
  - Frame length = NUM_COUNTERS + 2.
- Undefined: CHECK state, XOR accumulator and logic absent; frame length = NUM_COUNTERS + 1.

Decomposition:
- Shared package profiler_pkg:
  - state enum (IDLE, HEADER, DATA, CHECK)
  - HDR_MAGIC default and counter slot index constants (ICACHE_REQ_SLOT=0 ... DCACHE_FILL_SLOT=7)
- One natural sub-module: profile_stream_out_reg, a single-entry registered valid/ready output stage that holds data/last under back-pressure.

Test Plan:
- Counters 1..8 in slots 0..7, one snapshot_req, out_ready=1 -> words 0xCA5E0008, 1,2,...,8; out_last on word 8; header valid exactly 1 cycle after req.
- Change counters_in every cycle during a frame -> streamed values equal those present at the capture edge.
- out_ready toggled 1,0,0,1 pattern -> no word lost or duplicated; data/last stable while stalled; frame content identical to the unstalled case.
- snapshot_req pulsed 3 times mid-frame, plus once on the final xfer cycle -> dropped_req_count=4, one frame only; 300 dropped requests -> saturates at 255.
- 257 back-to-back frames -> header seq field runs 0x00..0xFF then 0x00; one idle cycle between frames.
- rst asserted during DATA idx=3 -> out_valid=0 next cycle, seq_id=0, next req yields header 0xCA5E0008; with PROFILER_STREAM_CHECKSUM_EN, counters 1..8 -> CHECK word = 0xCA5E0008 ^ 0x8 = 0xCA5E0000 with out_last.

Source files
------------

// File: rtl/profiler_pkg.sv
// Shared definitions for the cache profiler readout path: stream FSM
// states, default header magic and the counter slot map.
package profiler_pkg;

    localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hCA5E;

    // Counter slot positions inside the packed counters_in bus.
    localparam int ICACHE_REQ_SLOT  = 0;
    localparam int ICACHE_HIT_SLOT  = 1;
    localparam int ICACHE_MISS_SLOT = 2;
    localparam int DCACHE_REQ_SLOT  = 3;
    localparam int DCACHE_HIT_SLOT  = 4;
    localparam int DCACHE_MISS_SLOT = 5;
    localparam int ICACHE_FILL_SLOT = 6;
    localparam int DCACHE_FILL_SLOT = 7;

    // The state names the word currently held in the output register.
    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        CHECK
    } stream_state_e;

    function automatic logic [31:0] make_header(input logic [15:0] magic,
                                                input logic [7:0]  seq,
                                                input logic [7:0]  count);
        return {magic, seq, count};
    endfunction

endpackage

// File: rtl/profile_stream_out_reg.sv
// Single-entry registered valid/ready output stage. Holds data and last
// stable while the sink stalls; the owner only loads when the stage is
// empty or its current word is transferring this cycle.
module profile_stream_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         last_o,
    output logic         xfer_o
);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic         last_q;

    // Output register: load a new word, or drop valid once the word is taken.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
        end else if (xfer_o) begin
            valid_q <= 1'b0;
        end
    end

    assign xfer_o  = valid_q & ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/cache_profile_streamer.sv
// Captures the profiler counters coherently on a snapshot request and
// streams them as {header, counters[, checksum]} over valid/ready.
// Compile-time option: PROFILER_STREAM_CHECKSUM_EN appends an XOR check word.
module cache_profile_streamer
    import profiler_pkg::*;
#(
    parameter int          NUM_COUNTERS = 8,
    parameter logic [15:0] HDR_MAGIC    = HDR_MAGIC_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      snapshot_req,
    input  logic [32*NUM_COUNTERS-1:0] counters_in,
    output logic [31:0]               out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic [7:0]                dropped_req_count
);

    localparam int             IDX_W       = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_COUNTERS - 1);
    localparam logic [7:0]     COUNT_FIELD = 8'(NUM_COUNTERS);
`ifdef PROFILER_STREAM_CHECKSUM_EN
    localparam bit             CHK_EN      = 1'b1;
`else
    localparam bit             CHK_EN      = 1'b0;
`endif

    stream_state_e    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
    logic [7:0]       seq_q, seq_d;
    logic [7:0]       drop_q;
    logic [31:0]      cap_q [NUM_COUNTERS];
    logic             cap_en;
    logic             ld_en;
    logic [31:0]      ld_data;
    logic             ld_last;
    logic             xfer;
    logic [31:0]      header_word;
`ifdef PROFILER_STREAM_CHECKSUM_EN
    logic [31:0]      acc_q, acc_d;
`endif

    assign header_word = make_header(HDR_MAGIC, seq_q, COUNT_FIELD);
    assign nxt_idx     = idx_q + IDX_W'(1);

    // Next-state logic: each transfer loads the following word of the frame.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        cap_en  = 1'b0;
        ld_en   = 1'b0;
        ld_data = header_word;
        ld_last = 1'b0;
`ifdef PROFILER_STREAM_CHECKSUM_EN
        acc_d   = acc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (snapshot_req) begin
                    cap_en  = 1'b1;
                    ld_en   = 1'b1;
                    ld_data = header_word;
                    state_d = HEADER;
`ifdef PROFILER_STREAM_CHECKSUM_EN
                    acc_d   = header_word;
`endif
                end
            end
            HEADER: begin
                if (xfer) begin
                    ld_en   = 1'b1;
                    ld_data = cap_q[0];
                    ld_last = (LAST_IDX == '0) && !CHK_EN;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
`ifdef PROFILER_STREAM_CHECKSUM_EN
                    acc_d = acc_q ^ out_data;
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef PROFILER_STREAM_CHECKSUM_EN
                        ld_en   = 1'b1;
                        ld_data = acc_q ^ out_data;
                        ld_last = 1'b1;
                        state_d = CHECK;
`else
                        state_d = IDLE;
                        seq_d   = seq_q + 8'd1;
`endif
                    end else begin
                        ld_en   = 1'b1;
                        ld_data = cap_q[nxt_idx];
                        ld_last = (nxt_idx == LAST_IDX) && !CHK_EN;
                        idx_d   = nxt_idx;
                    end
                end
            end
`ifdef PROFILER_STREAM_CHECKSUM_EN
            CHECK: begin
                if (xfer) begin
                    state_d = IDLE;
                    seq_d   = seq_q + 8'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // FSM, word index and frame sequence registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
        end
    end

`ifdef PROFILER_STREAM_CHECKSUM_EN
    // Running XOR of every word already sent in this frame.
    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end
`endif

    // Coherent capture of all counters at the request edge; frozen until the next capture.
    // NOTE: this register bank is reset explicitly because its reset value is visible behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_COUNTERS; k++) cap_q[k] <= '0;
        end else if (cap_en) begin
            for (int k = 0; k < NUM_COUNTERS; k++) cap_q[k] <= counters_in[32*k +: 32];
        end
    end

    // Saturating count of requests arriving while a frame is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (snapshot_req && (state_q != IDLE) && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    profile_stream_out_reg #(.W(32)) u_out (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ld_en),
        .data_i  (ld_data),
        .last_i  (ld_last),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .data_o  (out_data),
        .last_o  (out_last),
        .xfer_o  (xfer)
    );

    assign busy              = (state_q != IDLE);
    assign dropped_req_count = drop_q;

endmodule

// File: tb/tb_cache_profile_streamer.sv
// Directed self-checking bench for cache_profile_streamer with a word
// scoreboard filled at request time and drained at each transfer.
module tb_cache_profile_streamer;

    localparam int NC = 8;
`ifdef PROFILER_STREAM_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int FRAME_LEN = NC + 1 + CHK;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } word_t;

    logic              clk;
    logic              rst;
    logic              snapshot_req;
    logic [32*NC-1:0]  counters_in;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic [7:0]        dropped_req_count;

    logic [31:0] cnt [NC];
    word_t       sb [$];
    logic [7:0]  exp_seq;
    int          n_cmp;
    int          n_err;

    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    cache_profile_streamer #(.NUM_COUNTERS(NC)) dut (
        .clk               (clk),
        .rst               (rst),
        .snapshot_req      (snapshot_req),
        .counters_in       (counters_in),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_last          (out_last),
        .busy              (busy),
        .dropped_req_count (dropped_req_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NC; k++) counters_in[32*k +: 32] = cnt[k];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the frame the DUT should emit for the counters driven now.
    task automatic push_frame();
        word_t       w;
        logic [31:0] acc;
        w.data = {16'hCA5E, exp_seq, 8'(NC)};
        w.last = 1'b0;
        sb.push_back(w);
        acc = w.data;
        for (int k = 0; k < NC; k++) begin
            w.data = cnt[k];
            w.last = (k == NC - 1) && (CHK == 0);
            sb.push_back(w);
            acc = acc ^ cnt[k];
        end
        if (CHK != 0) begin
            w.data = acc;
            w.last = 1'b1;
            sb.push_back(w);
        end
        exp_seq = exp_seq + 8'd1;
    endtask

    // mode 0: ready high; 1: ready high, counters scrambled; 2: ready 1,0,0,1 pattern
    task automatic run_frame(input int mode);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (mode == 2) out_ready = ((i % 4) == 0) || ((i % 4) == 3);
            else           out_ready = 1'b1;
            step();
            if (mode == 1) for (int k = 0; k < NC; k++) cnt[k] = $urandom;
            if (!busy && !out_valid) done = 1'b1;
        end
        out_ready = 1'b1;
        chk("frame_done", 32'(done), 32'd1);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic set_count_pattern();
        for (int k = 0; k < NC; k++) cnt[k] = 32'(k + 1);
    endtask

    // Transfer monitor: pops the scoreboard and checks stall stability.
    always @(negedge clk) begin : monitor
        word_t w;
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                chk("sb_has_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    w = sb.pop_front();
                    chk("word_data", out_data, w.data);
                    chk("word_last", 32'(out_last), 32'(w.last));
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
            prev_last  <= out_last;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done;
        n_cmp = 0;
        n_err = 0;
        exp_seq = 8'd0;
        rst = 1'b1;
        snapshot_req = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < NC; k++) cnt[k] = '0;

        // Reset state
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dropped", 32'(dropped_req_count), 32'd0);
        rst = 1'b0;
        step();

        // Basic frame, header one cycle after the request
        set_count_pattern();
        snapshot_req = 1'b1;
        push_frame();
        step();
        snapshot_req = 1'b0;
        chk("hdr_latency_valid", 32'(out_valid), 32'd1);
        chk("hdr_word", out_data, 32'hCA5E0008);
        chk("busy_in_frame", 32'(busy), 32'd1);
        run_frame(0);

        // Counters change every cycle after capture
        for (int k = 0; k < NC; k++) cnt[k] = $urandom;
        snapshot_req = 1'b1;
        push_frame();
        step();
        snapshot_req = 1'b0;
        run_frame(1);

        // Back-pressure pattern 1,0,0,1
        set_count_pattern();
        snapshot_req = 1'b1;
        push_frame();
        step();
        snapshot_req = 1'b0;
        run_frame(2);

        // Three mid-frame requests plus one on the final transfer
        snapshot_req = 1'b1;
        push_frame();
        step();
        snapshot_req = 1'b0;
        done = 0;
        for (int i = 1; i <= 40 && done == 0; i++) begin
            step();
            if (!busy && !out_valid) done = 1;
            else snapshot_req = (i == 2) || (i == 4) || (i == 6) || (out_valid && out_last);
        end
        snapshot_req = 1'b0;
        chk("drop_frame_done", 32'(done), 32'd1);
        chk("dropped_4", 32'(dropped_req_count), 32'd4);
        repeat (3) step();
        chk("no_refire_valid", 32'(out_valid), 32'd0);
        chk("no_refire_busy", 32'(busy), 32'd0);

        // Saturation: held request during a stalled frame
        out_ready = 1'b0;
        snapshot_req = 1'b1;
        push_frame();
        step();
        repeat (100) step();
        chk("dropped_104", 32'(dropped_req_count), 32'd104);
        repeat (200) step();
        chk("dropped_sat", 32'(dropped_req_count), 32'd255);
        snapshot_req = 1'b0;
        run_frame(0);

        // Reset clears counters and sequence
        rst = 1'b1;
        step();
        chk("rst2_dropped", 32'(dropped_req_count), 32'd0);
        rst = 1'b0;
        sb.delete();
        exp_seq = 8'd0;
        step();

        // 257 back-to-back frames with request held high
        for (int k = 0; k < NC; k++) cnt[k] = 32'h1000_0000 * 32'(k) + 32'h55;
        snapshot_req = 1'b1;
        for (int f = 0; f < 257; f++) begin
            push_frame();
            repeat (FRAME_LEN + 1) step();
            chk("gap_valid", 32'(out_valid), 32'd0);
            chk("gap_busy", 32'(busy), 32'd0);
        end
        snapshot_req = 1'b0;
        step();
        chk("b2b_sb_drained", sb.size(), 0);

        // Reset during DATA idx=3 aborts the frame
        set_count_pattern();
        snapshot_req = 1'b1;
        push_frame();
        step();
        snapshot_req = 1'b0;
        repeat (4) step();
        chk("idx3_word", out_data, 32'd4);
        rst = 1'b1;
        step();
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_last", 32'(out_last), 32'd0);
        sb.delete();
        rst = 1'b0;
        exp_seq = 8'd0;
        snapshot_req = 1'b1;
        push_frame();
        step();
        snapshot_req = 1'b0;
        chk("hdr_after_rst", out_data, 32'hCA5E0008);
        run_frame(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
